sdram_read_arbiter: RTL

//  Shares the single SDRAM read-burst port between two requesters:
//  - video row preload (VID): fixed priority, deadline-critical.
//  - auxiliary reader (AUX): e.g. scroll/copy engine.

---
 rtl/sdram_read_arbiter_if.sv | 48 ++++
 rtl/sdram_read_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/sdram_read_arbiter_if.sv
// Read-side bus bundle of the SDRAM read arbiter: two requester ports
// (VID, AUX), the single SDRAM controller read port, and status pulses.
interface sdram_read_arbiter_if;
  logic        vid_rd_request;
  logic [22:0] vid_rd_address;
  logic [8:0]  vid_rd_burst_length;
  logic        vid_rd_available;
  logic [31:0] vid_rd_data;
  logic        vid_busy;

  logic        aux_rd_request;
  logic [22:0] aux_rd_address;
  logic [8:0]  aux_rd_burst_length;
  logic        aux_rd_available;
  logic [31:0] aux_rd_data;
  logic        aux_busy;

  logic        sd_rd_request;
  logic [22:0] sd_rd_address;
  logic [8:0]  sd_rd_burst_length;
  logic        sd_rd_available;
  logic [31:0] sd_rd_data;

  logic        timeout;
  logic [1:0]  dropped;

  // Arbiter side
  modport slave (
    input  vid_rd_request, vid_rd_address, vid_rd_burst_length,
    output vid_rd_available, vid_rd_data, vid_busy,
    input  aux_rd_request, aux_rd_address, aux_rd_burst_length,
    output aux_rd_available, aux_rd_data, aux_busy,
    output sd_rd_request, sd_rd_address, sd_rd_burst_length,
    input  sd_rd_available, sd_rd_data,
    output timeout, dropped
  );

  // Requester / SDRAM-controller side
  modport master (
    output vid_rd_request, vid_rd_address, vid_rd_burst_length,
    input  vid_rd_available, vid_rd_data, vid_busy,
    output aux_rd_request, aux_rd_address, aux_rd_burst_length,
    input  aux_rd_available, aux_rd_data, aux_busy,
    input  sd_rd_request, sd_rd_address, sd_rd_burst_length,
    output sd_rd_available, sd_rd_data,
    input  timeout, dropped
  );
endinterface

// File: rtl/sdram_read_arbiter.sv
// Shares the SDRAM read-burst port between the video row preload (VID,
// fixed priority) and an auxiliary reader (AUX). Request pulses are held in
// one pending slot per port, one burst is in flight at a time, returned words
// are routed to the burst owner, and stalled bursts are aborted on timeout.
module sdram_read_arbiter #(
  parameter int unsigned AUX_MAX_BURST  = 80,
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned TIMEOUT_DEPTH  = 10
) (
  input logic                 clk,
  input logic                 reset,
  sdram_read_arbiter_if.slave bus
);

  typedef enum logic {S_IDLE, S_BURST} state_t;
  typedef enum logic {OWN_VID, OWN_AUX} owner_t;

  localparam logic [8:0]               AUX_CAP  = 9'(AUX_MAX_BURST);
  localparam logic [TIMEOUT_DEPTH-1:0] TMO_LAST = TIMEOUT_DEPTH'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_DEPTH-1:0] TMO_SAT  = '1;
  localparam logic [TIMEOUT_DEPTH-1:0] TMO_ONE  = TIMEOUT_DEPTH'(1);

  state_t                   r_state;
  owner_t                   r_owner;
  logic [8:0]               r_remaining;
  logic [TIMEOUT_DEPTH-1:0] r_tmo;

  logic                     r_vid_pend;
  logic [22:0]              r_vid_addr;
  logic [8:0]               r_vid_len;
  logic                     r_aux_pend;
  logic [22:0]              r_aux_addr;
  logic [8:0]               r_aux_len;

  logic                     r_sd_req;
  logic [22:0]              r_sd_addr;
  logic [8:0]               r_sd_len;
  logic                     r_vid_avail;
  logic [31:0]              r_vid_data;
  logic                     r_aux_avail;
  logic [31:0]              r_aux_data;
  logic                     r_timeout;
  logic [1:0]               r_dropped;

  logic [8:0]               w_aux_len;
  logic                     w_grant_vid;
  logic                     w_grant_aux;

  assign w_aux_len   = (r_aux_len > AUX_CAP) ? AUX_CAP : r_aux_len;
  assign w_grant_vid = (r_state == S_IDLE) && r_vid_pend;
  assign w_grant_aux = (r_state == S_IDLE) && !r_vid_pend && r_aux_pend;

  // Request latching, grant FSM, burst tracking and word routing
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_VID;
      r_remaining <= '0;
      r_tmo       <= '0;
      r_vid_pend  <= 1'b0;
      r_vid_addr  <= '0;
      r_vid_len   <= '0;
      r_aux_pend  <= 1'b0;
      r_aux_addr  <= '0;
      r_aux_len   <= '0;
      r_sd_req    <= 1'b0;
      r_sd_addr   <= '0;
      r_sd_len    <= '0;
      r_vid_avail <= 1'b0;
      r_vid_data  <= '0;
      r_aux_avail <= 1'b0;
      r_aux_data  <= '0;
      r_timeout   <= 1'b0;
      r_dropped   <= '0;
    end else begin
      r_sd_req    <= 1'b0;
      r_vid_avail <= 1'b0;
      r_aux_avail <= 1'b0;
      r_timeout   <= 1'b0;
      r_dropped   <= '0;

      // A slot that is full at this edge rejects the request even if it is
      // being granted on the same edge; a grant needs a full slot and a
      // latch needs an empty one, so the two never touch the slot together.
      if (bus.vid_rd_request) begin
        if (r_vid_pend) begin
          r_dropped[0] <= 1'b1;
        end else begin
          r_vid_pend <= 1'b1;
          r_vid_addr <= bus.vid_rd_address;
          r_vid_len  <= bus.vid_rd_burst_length;
        end
      end
      if (bus.aux_rd_request) begin
        if (r_aux_pend) begin
          r_dropped[1] <= 1'b1;
        end else begin
          r_aux_pend <= 1'b1;
          r_aux_addr <= bus.aux_rd_address;
          r_aux_len  <= bus.aux_rd_burst_length;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (w_grant_vid) begin
            r_vid_pend  <= 1'b0;
            r_owner     <= OWN_VID;
            r_remaining <= r_vid_len;
            r_tmo       <= '0;
            if (r_vid_len != '0) begin
              r_sd_req  <= 1'b1;
              r_sd_addr <= r_vid_addr;
              r_sd_len  <= r_vid_len;
              r_state   <= S_BURST;
            end
          end else if (w_grant_aux) begin
            r_aux_pend  <= 1'b0;
            r_owner     <= OWN_AUX;
            r_remaining <= w_aux_len;
            r_tmo       <= '0;
            if (w_aux_len != '0) begin
              r_sd_req  <= 1'b1;
              r_sd_addr <= r_aux_addr;
              r_sd_len  <= w_aux_len;
              r_state   <= S_BURST;
            end
          end
        end
        S_BURST: begin
          if (bus.sd_rd_available) begin
            if (r_owner == OWN_VID) begin
              r_vid_avail <= 1'b1;
              r_vid_data  <= bus.sd_rd_data;
            end else begin
              r_aux_avail <= 1'b1;
              r_aux_data  <= bus.sd_rd_data;
            end
            if (r_remaining != '0) r_remaining <= r_remaining - 9'd1;
            r_tmo <= '0;
            if (r_remaining <= 9'd1) r_state <= S_IDLE;
          end else if (r_tmo == TMO_LAST) begin
            r_state     <= S_IDLE;
            r_timeout   <= 1'b1;
            r_remaining <= '0;
          end else if (r_tmo != TMO_SAT) begin
            r_tmo <= r_tmo + TMO_ONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.sd_rd_request      = r_sd_req;
  assign bus.sd_rd_address      = r_sd_addr;
  assign bus.sd_rd_burst_length = r_sd_len;
  assign bus.vid_rd_available   = r_vid_avail;
  assign bus.vid_rd_data        = r_vid_data;
  assign bus.aux_rd_available   = r_aux_avail;
  assign bus.aux_rd_data        = r_aux_data;
  assign bus.timeout            = r_timeout;
  assign bus.dropped            = r_dropped;
  assign bus.vid_busy           = r_vid_pend || ((r_state == S_BURST) && (r_owner == OWN_VID));
  assign bus.aux_busy           = r_aux_pend || ((r_state == S_BURST) && (r_owner == OWN_AUX));

endmodule
